// File: rtl/aes128_sched_if.sv
// ---------------------------------------------------------------------------
// aes128_sched_if
//   Groups the request/response channels the AES-128 job sequencer talks to:
//   the CCI-P/MPF read channel, the AES line pipeline and the write channel.
//
//   Read channel : rd_req_valid, rd_req_addr (out), rd_almfull, rd_rsp_valid,
//                  rd_rsp_data (in)
//   AES pipeline : key, aes_in_valid, aes_in_data (out), aes_out_valid,
//                  aes_out_data (in)
//   Write channel: wr_req_valid, wr_req_addr, wr_req_data (out), wr_almfull (in)
//
//   "master" is the sequencer side, "slave" is the memory/pipeline side.
// ---------------------------------------------------------------------------
interface aes128_sched_if #(
   parameter int ADDR_W = 42
);
   logic              rd_req_valid;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_almfull;
   logic              rd_rsp_valid;
   logic [511:0]      rd_rsp_data;

   logic [127:0]      key;
   logic              aes_in_valid;
   logic [511:0]      aes_in_data;
   logic              aes_out_valid;
   logic [511:0]      aes_out_data;

   logic              wr_req_valid;
   logic [ADDR_W-1:0] wr_req_addr;
   logic [511:0]      wr_req_data;
   logic              wr_almfull;

   modport master (
      output rd_req_valid, rd_req_addr,
      input  rd_almfull, rd_rsp_valid, rd_rsp_data,
      output key, aes_in_valid, aes_in_data,
      input  aes_out_valid, aes_out_data,
      output wr_req_valid, wr_req_addr, wr_req_data,
      input  wr_almfull
   );

   modport slave (
      input  rd_req_valid, rd_req_addr,
      output rd_almfull, rd_rsp_valid, rd_rsp_data,
      input  key, aes_in_valid, aes_in_data,
      output aes_out_valid, aes_out_data,
      input  wr_req_valid, wr_req_addr, wr_req_data,
      output wr_almfull
   );
endinterface

// File: rtl/aes128_sched.sv
// ---------------------------------------------------------------------------
// aes128_sched
//   Job sequencer for the AES-128 accelerator. A rising edge on
//   hc_control[0] while idle latches the job descriptor, reads the key line,
//   streams the source lines through the AES pipeline, buffers the encrypted
//   lines in a result FIFO, writes them to the destination and finally posts
//   a completion record to the DSM line.
//
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     hc_control     bit0 = start (edge triggered), other bits ignored
//     dsm_base       DSM line address for the completion record
//     key_addr       line holding the key in bits [127:0]
//     src_addr       source base line
//     dst_addr       destination base line
//     src_size       job size in bytes
//     busy           job in progress
//     done           last job completed, cleared on the next start
//     bus            read channel, AES pipeline and write channel (master)
// ---------------------------------------------------------------------------
module aes128_sched #(
   parameter int ADDR_W         = 42,
   parameter int OUT_FIFO_DEPTH = 16,
   parameter int SIZE_W         = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       hc_control,
   input  logic [ADDR_W-1:0] dsm_base,
   input  logic [ADDR_W-1:0] key_addr,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [SIZE_W-1:0] src_size,
   output logic              busy,
   output logic              done,
   aes128_sched_if.master    bus
);

   // A line count never needs more than SIZE_W-5 bits: (2^SIZE_W-1+63)>>6.
   localparam int NL_W = SIZE_W - 5;
   localparam int FA_W = $clog2(OUT_FIFO_DEPTH);

   localparam logic [SIZE_W:0] ROUND_ADD = (SIZE_W+1)'(63);
   localparam logic [NL_W-1:0] NL_ONE    = NL_W'(1);
   localparam logic [NL_W-1:0] CREDITS   = NL_W'(OUT_FIFO_DEPTH);
   localparam logic [FA_W-1:0] PTR_ONE   = FA_W'(1);
   localparam logic [FA_W:0]   CNT_ONE   = (FA_W+1)'(1);
   localparam logic [FA_W:0]   CNT_FULL  = (FA_W+1)'(OUT_FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      KEY_RD,
      KEY_WAIT,
      RUN,
      DSM_WR
   } state_t;

   state_t            state;
   logic              start_prev;
   logic              start;

   logic [ADDR_W-1:0] dsm_q;
   logic [ADDR_W-1:0] key_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [NL_W-1:0]   nlines;
   logic [NL_W-1:0]   rd_issued;
   logic [NL_W-1:0]   wr_done;
   logic [SIZE_W:0]   size_round;

   logic [511:0]      fifo_mem [OUT_FIFO_DEPTH];
   logic [FA_W-1:0]   fifo_wp;
   logic [FA_W-1:0]   fifo_rp;
   logic [FA_W:0]     fifo_cnt;
   logic              fifo_empty;
   logic              fifo_full;

   logic              push;
   logic              pop;
   logic              rd_go;
   logic [1:0]        unused_bits;

   assign start      = hc_control[0] & ~start_prev;
   assign size_round = {1'b0, src_size} + ROUND_ADD;
   assign unused_bits = {^hc_control[31:1], ^size_round[5:0]};

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_FULL);

   // Datapath traffic is only accepted while running; stale responses or
   // pipeline output that trickle in after a reset or abort are dropped.
   assign push = (state == RUN) & bus.aes_out_valid;
   assign pop  = (state == RUN) & ~fifo_empty & ~bus.wr_almfull;

   // Credit rule: every line read but not yet written owns a FIFO slot, so
   // limiting lines in flight to the FIFO depth makes overflow impossible.
   assign rd_go = (state == RUN) & (rd_issued < nlines) & ~bus.rd_almfull
                  & ((rd_issued - wr_done) < CREDITS);

   // Result storage has no reset so it can map onto RAM; only the pointers
   // and the occupancy count carry state that matters.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[fifo_wp] <= bus.aes_out_data;
      end
   end

   // Sequencer: start detection, descriptor latching, read issue, AES feed,
   // result FIFO bookkeeping, destination writes and the completion record.
   // All outputs are registered; request strobes are single-cycle pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         start_prev       <= 1'b0;
         dsm_q            <= '0;
         key_q            <= '0;
         src_q            <= '0;
         dst_q            <= '0;
         nlines           <= '0;
         rd_issued        <= '0;
         wr_done          <= '0;
         fifo_wp          <= '0;
         fifo_rp          <= '0;
         fifo_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         bus.rd_req_valid <= 1'b0;
         bus.rd_req_addr  <= '0;
         bus.key          <= '0;
         bus.aes_in_valid <= 1'b0;
         bus.aes_in_data  <= '0;
         bus.wr_req_valid <= 1'b0;
         bus.wr_req_addr  <= '0;
         bus.wr_req_data  <= '0;
      end else begin
         start_prev       <= hc_control[0];
         bus.rd_req_valid <= 1'b0;
         bus.wr_req_valid <= 1'b0;
         bus.aes_in_valid <= 1'b0;

         if (push) begin
            fifo_wp <= fifo_wp + PTR_ONE;
         end

         if (pop) begin
            fifo_rp          <= fifo_rp + PTR_ONE;
            bus.wr_req_valid <= 1'b1;
            bus.wr_req_addr  <= dst_q + ADDR_W'(wr_done);
            bus.wr_req_data  <= fifo_mem[fifo_rp];
            wr_done          <= wr_done + NL_ONE;
         end

         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (rd_go) begin
            bus.rd_req_valid <= 1'b1;
            bus.rd_req_addr  <= src_q + ADDR_W'(rd_issued);
            rd_issued        <= rd_issued + NL_ONE;
         end

         // Source lines go straight into the AES pipeline one cycle later;
         // the pipeline never stalls, so no buffering is needed here.
         if ((state == RUN) && bus.rd_rsp_valid) begin
            bus.aes_in_valid <= 1'b1;
            bus.aes_in_data  <= bus.rd_rsp_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  dsm_q     <= dsm_base;
                  key_q     <= key_addr;
                  src_q     <= src_addr;
                  dst_q     <= dst_addr;
                  nlines    <= size_round[SIZE_W:6];
                  rd_issued <= '0;
                  wr_done   <= '0;
                  fifo_wp   <= '0;
                  fifo_rp   <= '0;
                  fifo_cnt  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  state     <= KEY_RD;
               end
            end
            KEY_RD: begin
               if (!bus.rd_almfull) begin
                  bus.rd_req_valid <= 1'b1;
                  bus.rd_req_addr  <= key_q;
                  state            <= KEY_WAIT;
               end
            end
            KEY_WAIT: begin
               if (bus.rd_rsp_valid) begin
                  bus.key <= bus.rd_rsp_data[127:0];
                  state   <= (nlines == '0) ? DSM_WR : RUN;
               end
            end
            RUN: begin
               if (wr_done == nlines) begin
                  state <= DSM_WR;
               end
            end
            DSM_WR: begin
               // Completion record: bit0 = valid, [63:32] = lines processed.
               if (!bus.wr_almfull) begin
                  bus.wr_req_valid <= 1'b1;
                  bus.wr_req_addr  <= dsm_q;
                  bus.wr_req_data  <= {448'b0, 32'(nlines), 31'b0, 1'b1};
                  done             <= 1'b1;
                  busy             <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The credit rule makes this unreachable; firing means in-flight
   // accounting is broken and results would be silently lost.
   fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && fifo_full))
      else $fatal(1, "aes128_sched: result FIFO push while full");

endmodule

// File: tb/tb_aes128_sched.sv
// ---------------------------------------------------------------------------
// tb_aes128_sched
//   Directed bench for the AES-128 job sequencer. A fixed-latency in-order
//   memory model answers reads, a fixed-latency XOR pipeline stands in for
//   the AES core, and a negedge monitor records every request for the
//   per-scenario tasks to compare against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_aes128_sched;

   localparam int ADDR_W = 42;
   localparam logic [511:0] AES_MASK = {16{32'hDEADBEEF}};

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [31:0]       hc_control = '0;
   logic [ADDR_W-1:0] dsm_base = '0;
   logic [ADDR_W-1:0] key_addr = '0;
   logic [ADDR_W-1:0] src_addr = '0;
   logic [ADDR_W-1:0] dst_addr = '0;
   logic [31:0]       src_size = '0;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   aes128_sched_if #(.ADDR_W(ADDR_W)) bus ();

   aes128_sched #(.ADDR_W(ADDR_W), .OUT_FIFO_DEPTH(16), .SIZE_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .hc_control (hc_control),
      .dsm_base   (dsm_base),
      .key_addr   (key_addr),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .src_size   (src_size),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Back-pressure: forced levels plus optional per-cycle random levels.
   logic rd_af_force = 1'b0;
   logic wr_af_force = 1'b0;
   logic rand_en = 1'b0;
   logic rand_rd = 1'b0;
   logic rand_wr = 1'b0;
   assign bus.rd_almfull = rd_af_force | (rand_en & rand_rd);
   assign bus.wr_almfull = wr_af_force | (rand_en & rand_wr);

   // Memory contents: the configured key line, otherwise a per-address pattern.
   logic [ADDR_W-1:0] key_line_addr = '0;
   logic [511:0]      key_line = '0;

   function automatic logic [511:0] mem_line(input logic [ADDR_W-1:0] a);
      logic [511:0] l;
      if (a == key_line_addr) return key_line;
      for (int i = 0; i < 16; i++) l[32*i +: 32] = a[31:0] + 32'(i) * 32'h01010101;
      return l;
   endfunction

   // In-order memory with 4 cycles of request-to-response latency.
   logic [3:0]        mem_v = '0;
   logic [ADDR_W-1:0] mem_a [4];
   always @(posedge clk) begin
      mem_v <= {mem_v[2:0], bus.rd_req_valid};
      mem_a[0] <= bus.rd_req_addr;
      for (int i = 1; i < 4; i++) mem_a[i] <= mem_a[i-1];
      bus.rd_rsp_valid <= mem_v[3];
      bus.rd_rsp_data  <= mem_line(mem_a[3]);
   end

   // Stand-in AES pipeline: XOR with a mask, 5-stage in-order latency.
   logic [4:0]   aes_v = '0;
   logic [511:0] aes_d [5];
   always @(posedge clk) begin
      aes_v <= {aes_v[3:0], bus.aes_in_valid};
      aes_d[0] <= bus.aes_in_data ^ AES_MASK;
      for (int i = 1; i < 5; i++) aes_d[i] <= aes_d[i-1];
      bus.aes_out_valid <= aes_v[4];
      bus.aes_out_data  <= aes_d[4];
   end

   // Almost-full levels as seen by the DUT at each active edge.
   logic rd_af_edge = 1'b0;
   logic wr_af_edge = 1'b0;
   always @(posedge clk) begin
      rd_af_edge <= bus.rd_almfull;
      wr_af_edge <= bus.wr_almfull;
   end

   // Monitor: records requests and counts requests issued under almost-full.
   logic [ADDR_W-1:0] rd_q[$];
   logic [ADDR_W-1:0] wr_a_q[$];
   logic [511:0]      wr_d_q[$];
   int aes_in_cnt = 0;
   int af_viol = 0;
   always @(negedge clk) begin
      if (bus.rd_req_valid === 1'b1) begin
         rd_q.push_back(bus.rd_req_addr);
         if (rd_af_edge) af_viol++;
      end
      if (bus.wr_req_valid === 1'b1) begin
         wr_a_q.push_back(bus.wr_req_addr);
         wr_d_q.push_back(bus.wr_req_data);
         if (wr_af_edge) af_viol++;
      end
      if (bus.aes_in_valid === 1'b1) aes_in_cnt++;
      rand_rd = 1'($urandom_range(0, 1));
      rand_wr = 1'($urandom_range(0, 1));
   end

   task automatic setup_job(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] m,
                            input logic [31:0] sz);
      key_addr = k;
      src_addr = s;
      dst_addr = d;
      dsm_base = m;
      src_size = sz;
      rd_q.delete();
      wr_a_q.delete();
      wr_d_q.delete();
      aes_in_cnt = 0;
      af_viol = 0;
   endtask

   task automatic pulse_start(input bit hold);
      @(negedge clk);
      hc_control = 32'h1;
      @(negedge clk);
      if (!hold) hc_control = 32'h0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.rd_req_valid, bus.wr_req_valid, bus.aes_in_valid, busy, done} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_strobes: got %b expected 00000",
                  {bus.rd_req_valid, bus.wr_req_valid, bus.aes_in_valid, busy, done});
      end
      checks++;
      if (bus.key !== 128'h0) begin
         errors++;
         $display("[TB] FAIL reset_key: got %h expected 0", bus.key);
      end
      checks++;
      if ({bus.rd_req_addr, bus.wr_req_addr} !== '0 || bus.wr_req_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_addr_data: got rd %h wr %h expected 0", bus.rd_req_addr, bus.wr_req_addr);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_size;
      bit ok;
      key_line_addr = 42'h100;
      key_line = 512'h00112233;
      setup_job(42'h100, 42'h1000, 42'h2000, 42'h3000, 32'd0);
      pulse_start(1'b0);
      wait_done(200, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", ok); end
      checks++;
      if (rd_q.size() != 1 || rd_q[0] !== 42'h100) begin
         errors++;
         $display("[TB] FAIL zero_reads: got %0d reads first %h expected 1 read at 100", rd_q.size(), rd_q[0]);
      end
      checks++;
      if (aes_in_cnt != 0) begin errors++; $display("[TB] FAIL zero_aes_in: got %0d expected 0", aes_in_cnt); end
      checks++;
      if (wr_a_q.size() != 1 || wr_a_q[0] !== 42'h3000 || wr_d_q[0] !== 512'h1) begin
         errors++;
         $display("[TB] FAIL zero_dsm: got %0d writes addr %h data %h expected 1 write at 3000 data 1",
                  wr_a_q.size(), wr_a_q[0], wr_d_q[0]);
      end
      checks++;
      if (bus.key !== 128'h00112233) begin
         errors++;
         $display("[TB] FAIL zero_key: got %h expected 00112233", bus.key);
      end
   endtask

   task automatic test_single_line;
      bit ok;
      key_line_addr = 42'h200;
      key_line = {{12{32'hCAFEF00D}}, 128'h000102030405060708090A0B0C0D0E0F};
      setup_job(42'h200, 42'h4000, 42'h5000, 42'h6000, 32'd1);
      pulse_start(1'b0);
      wait_done(300, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b expected 1", ok); end
      checks++;
      if (rd_q.size() != 2 || rd_q[1] !== 42'h4000) begin
         errors++;
         $display("[TB] FAIL single_reads: got %0d reads second %h expected 2 reads, second 4000", rd_q.size(), rd_q[1]);
      end
      checks++;
      if (aes_in_cnt != 1) begin errors++; $display("[TB] FAIL single_aes_in: got %0d expected 1", aes_in_cnt); end
      checks++;
      if (wr_a_q.size() != 2 || wr_a_q[0] !== 42'h5000 || wr_d_q[0] !== (mem_line(42'h4000) ^ AES_MASK)) begin
         errors++;
         $display("[TB] FAIL single_data_wr: got %0d writes addr %h data %h expected addr 5000 data %h",
                  wr_a_q.size(), wr_a_q[0], wr_d_q[0], mem_line(42'h4000) ^ AES_MASK);
      end
      checks++;
      if (wr_a_q[1] !== 42'h6000 || wr_d_q[1] !== 512'h1_0000_0001) begin
         errors++;
         $display("[TB] FAIL single_dsm: got addr %h data %h expected 6000 / 100000001", wr_a_q[1], wr_d_q[1]);
      end
      checks++;
      if (bus.key !== 128'h000102030405060708090A0B0C0D0E0F) begin
         errors++;
         $display("[TB] FAIL single_key: got %h expected 000102030405060708090a0b0c0d0e0f", bus.key);
      end
   endtask

   task automatic test_back_pressure;
      bit ok;
      int bad_rd;
      int bad_wr;
      key_line_addr = 42'h300;
      key_line = 512'h5555;
      setup_job(42'h300, 42'h10000, 42'h20000, 42'h30000, 32'd4096);
      wr_af_force = 1'b1;
      pulse_start(1'b0);
      repeat (200) @(negedge clk);
      #1;
      checks++;
      if (rd_q.size() != 17 || wr_a_q.size() != 0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_stall: got %0d reads %0d writes busy %b expected 17 reads 0 writes busy 1",
                  rd_q.size(), wr_a_q.size(), busy);
      end
      wr_af_force = 1'b0;
      wait_done(3000, ok);
      checks++;
      if (ok !== 1'b1 || rd_q.size() != 65 || wr_a_q.size() != 65) begin
         errors++;
         $display("[TB] FAIL bp_counts: got done %b reads %0d writes %0d expected 1/65/65", ok, rd_q.size(), wr_a_q.size());
      end
      bad_rd = 0;
      bad_wr = 0;
      for (int i = 0; i < 64; i++) begin
         if (rd_q[i+1] !== 42'h10000 + 42'(i)) bad_rd++;
         if (wr_a_q[i] !== 42'h20000 + 42'(i) ||
             wr_d_q[i] !== (mem_line(42'h10000 + 42'(i)) ^ AES_MASK)) bad_wr++;
      end
      checks++;
      if (bad_rd != 0) begin errors++; $display("[TB] FAIL bp_read_order: got %0d bad addresses expected 0", bad_rd); end
      checks++;
      if (bad_wr != 0) begin errors++; $display("[TB] FAIL bp_write_order: got %0d bad writes expected 0", bad_wr); end
      checks++;
      if (wr_a_q[64] !== 42'h30000 || wr_d_q[64] !== 512'h40_0000_0001) begin
         errors++;
         $display("[TB] FAIL bp_dsm: got addr %h data %h expected 30000 / 4000000001", wr_a_q[64], wr_d_q[64]);
      end
      checks++;
      if (af_viol != 0) begin errors++; $display("[TB] FAIL bp_almfull: got %0d violations expected 0", af_viol); end
   endtask

   task automatic test_almfull_gating;
      bit ok;
      int bad_rd;
      int bad_wr;
      logic [ADDR_W-1:0] dst;
      dst = 42'h3FF_FFFF_FFF8;
      key_line_addr = 42'h400;
      key_line = 512'hAAAA;
      setup_job(42'h400, 42'h3_0000_0000, dst, 42'h40000, 32'd1270);
      rand_en = 1'b1;
      pulse_start(1'b0);
      wait_done(3000, ok);
      rand_en = 1'b0;
      checks++;
      if (ok !== 1'b1 || rd_q.size() != 21 || wr_a_q.size() != 21) begin
         errors++;
         $display("[TB] FAIL af_counts: got done %b reads %0d writes %0d expected 1/21/21", ok, rd_q.size(), wr_a_q.size());
      end
      checks++;
      if (af_viol != 0) begin errors++; $display("[TB] FAIL af_gating: got %0d violations expected 0", af_viol); end
      bad_rd = 0;
      bad_wr = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_q[i+1] !== 42'h3_0000_0000 + 42'(i)) bad_rd++;
         if (wr_a_q[i] !== dst + 42'(i) ||
             wr_d_q[i] !== (mem_line(42'h3_0000_0000 + 42'(i)) ^ AES_MASK)) bad_wr++;
      end
      checks++;
      if (bad_rd != 0) begin errors++; $display("[TB] FAIL af_contiguous: got %0d bad addresses expected 0", bad_rd); end
      checks++;
      if (bad_wr != 0) begin errors++; $display("[TB] FAIL af_writes: got %0d bad writes expected 0", bad_wr); end
      checks++;
      if (wr_d_q[20] !== 512'h14_0000_0001) begin
         errors++;
         $display("[TB] FAIL af_dsm: got %h expected 1400000001", wr_d_q[20]);
      end
   endtask

   task automatic test_start_filtering;
      bit ok;
      int bad_wr;
      key_line_addr = 42'h500;
      key_line = 512'hBBBB;
      setup_job(42'h500, 42'h100, 42'h200, 42'h300, 32'd128);
      pulse_start(1'b1);
      wait_done(300, ok);
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (ok !== 1'b1 || rd_q.size() != 3 || wr_a_q.size() != 3 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL filter_hold: got done %b reads %0d writes %0d busy %b expected 1/3/3/0",
                  ok, rd_q.size(), wr_a_q.size(), busy);
      end

      hc_control = 32'h0;
      repeat (2) @(negedge clk);
      setup_job(42'h500, 42'h800, 42'h900, 42'hA00, 32'd512);
      wr_af_force = 1'b1;
      pulse_start(1'b0);
      repeat (20) @(negedge clk);
      src_addr = 42'hFFF00;
      dst_addr = 42'hEEE00;
      pulse_start(1'b0);
      repeat (5) @(negedge clk);
      wr_af_force = 1'b0;
      wait_done(500, ok);
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (ok !== 1'b1 || rd_q.size() != 9 || wr_a_q.size() != 9) begin
         errors++;
         $display("[TB] FAIL filter_run_edge: got done %b reads %0d writes %0d expected 1/9/9", ok, rd_q.size(), wr_a_q.size());
      end
      bad_wr = 0;
      for (int i = 0; i < 8; i++) if (wr_a_q[i] !== 42'h900 + 42'(i)) bad_wr++;
      checks++;
      if (bad_wr != 0 || wr_a_q[8] !== 42'hA00 || wr_d_q[8] !== 512'h8_0000_0001) begin
         errors++;
         $display("[TB] FAIL filter_run_addrs: got %0d bad addrs dsm %h data %h expected 0 / a00 / 800000001",
                  bad_wr, wr_a_q[8], wr_d_q[8]);
      end

      setup_job(42'h500, 42'h1100, 42'h1200, 42'h1300, 32'd64);
      @(negedge clk);
      hc_control = 32'h1;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL filter_restart: got done %b busy %b expected 0/1", done, busy);
      end
      hc_control = 32'h0;
      wait_done(300, ok);
      checks++;
      if (ok !== 1'b1 || wr_a_q.size() != 2 || wr_a_q[0] !== 42'h1200) begin
         errors++;
         $display("[TB] FAIL filter_restart_job: got done %b writes %0d first %h expected 1/2/1200", ok, wr_a_q.size(), wr_a_q[0]);
      end
   endtask

   task automatic test_reset_mid_job;
      bit ok;
      bit reached;
      int aes_snap;
      int rd_snap;
      int wr_snap;
      int bad_wr;
      key_line_addr = 42'h600;
      key_line = {{12{32'h0}}, 128'hFEDCBA98765432100123456789ABCDEF};
      setup_job(42'h600, 42'h7000, 42'h8000, 42'h9000, 32'd2048);
      pulse_start(1'b0);
      reached = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (wr_a_q.size() >= 10) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (reached !== 1'b1) begin errors++; $display("[TB] FAIL rst_progress: got %0d writes expected >= 10", wr_a_q.size()); end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.rd_req_valid, bus.wr_req_valid, bus.aes_in_valid, busy, done} !== 5'b0 ||
          bus.key !== '0 || bus.rd_req_addr !== '0 || bus.wr_req_addr !== '0 ||
          bus.wr_req_data !== '0 || bus.aes_in_data !== '0) begin
         errors++;
         $display("[TB] FAIL rst_outputs: got strobes %b key %h expected all zero",
                  {bus.rd_req_valid, bus.wr_req_valid, bus.aes_in_valid, busy, done}, bus.key);
      end
      aes_snap = aes_in_cnt;
      rd_snap = rd_q.size();
      wr_snap = wr_a_q.size();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (aes_in_cnt != aes_snap || rd_q.size() != rd_snap || wr_a_q.size() != wr_snap || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_late_rsp: got aes_in +%0d reads +%0d writes +%0d busy %b expected 0/0/0/0",
                  aes_in_cnt - aes_snap, rd_q.size() - rd_snap, wr_a_q.size() - wr_snap, busy);
      end

      setup_job(42'h600, 42'hA000, 42'hB000, 42'hC000, 32'd192);
      pulse_start(1'b0);
      wait_done(300, ok);
      bad_wr = 0;
      for (int i = 0; i < 3; i++)
         if (wr_a_q[i] !== 42'hB000 + 42'(i) || wr_d_q[i] !== (mem_line(42'hA000 + 42'(i)) ^ AES_MASK)) bad_wr++;
      checks++;
      if (ok !== 1'b1 || wr_a_q.size() != 4 || bad_wr != 0) begin
         errors++;
         $display("[TB] FAIL rst_clean_job: got done %b writes %0d bad %0d expected 1/4/0", ok, wr_a_q.size(), bad_wr);
      end
      checks++;
      if (wr_d_q[3] !== 512'h3_0000_0001 || bus.key !== 128'hFEDCBA98765432100123456789ABCDEF) begin
         errors++;
         $display("[TB] FAIL rst_clean_dsm_key: got dsm %h key %h expected 300000001 / fedcba98765432100123456789abcdef",
                  wr_d_q[3], bus.key);
      end
   endtask

   initial begin
      test_reset();
      test_zero_size();
      test_single_line();
      test_back_pressure();
      test_almfull_gating();
      test_start_filtering();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
